// File: rtl/ofifo_col.sv
// ofifo_col: output FIFO behind the MAC row array.
// Each column has its own circular buffer, written on its own strobe, so the
// column skew from the array is absorbed. Rows are paired by entry index.
// A pop removes one entry from every column at once and registers the row.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in         column c psum on bits [psum_bw*(c+1)-1 : psum_bw*c]
//   wr         per-column write strobe
//   rd         pop request for one aligned row
//   out        registered popped row (same packing as in)
//   out_strobe high the cycle after an accepted pop
//   o_valid    every column non-empty (combinational)
//   o_full     some column holds depth entries (combinational)
//   o_ready    ~o_full (combinational)
//   overflow   sticky: a write was dropped
module ofifo_col #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_strobe,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = psum_bw * col;

  logic [psum_bw-1:0] mem_q [col][depth];

  logic [AW-1:0] wptr_q [col];
  logic [AW-1:0] wptr_d [col];
  logic [AW-1:0] rptr_q [col];
  logic [AW-1:0] rptr_d [col];
  logic [CW-1:0] cnt_q  [col];
  logic [CW-1:0] cnt_d  [col];

  logic [RW-1:0]  out_q, out_d;
  logic           strobe_q, strobe_d;
  logic           ovf_q, ovf_d;
  logic [RW-1:0]  head;
  logic [col-1:0] wr_acc;
  logic           valid_c, full_c, pop_c, drop_c;

  // Row-level flags straight from the per-column counts.
  always_comb begin
    valid_c = 1'b1;
    full_c  = 1'b0;
    for (int unsigned c = 0; c < col; c++) begin
      if (cnt_q[c] == '0)         valid_c = 1'b0;
      if (cnt_q[c] == CW'(depth)) full_c  = 1'b1;
    end
  end

  assign pop_c = rd & valid_c;

  // Per-column write acceptance, pointer and count updates.
  // A full column still accepts a write when a pop frees a slot this cycle.
  always_comb begin
    wr_acc = '0;
    drop_c = 1'b0;
    head   = '0;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    for (int unsigned c = 0; c < col; c++) begin
      head[c*psum_bw +: psum_bw] = mem_q[c][rptr_q[c]];
      wr_acc[c] = wr[c] & ((cnt_q[c] != CW'(depth)) | pop_c);
      if (wr[c] && !wr_acc[c]) drop_c = 1'b1;
      if (wr_acc[c]) wptr_d[c] = wptr_q[c] + AW'(1);
      if (pop_c)     rptr_d[c] = rptr_q[c] + AW'(1);
      cnt_d[c] = cnt_q[c] + CW'(wr_acc[c]) - CW'(pop_c);
    end
  end

  // Registered output row, strobe and sticky overflow.
  always_comb begin
    out_d    = out_q;
    strobe_d = pop_c;
    ovf_d    = ovf_q | drop_c;
    if (pop_c) out_d = head;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < col; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      out_q    <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: pointers and counts define what is live.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < col; c++) begin
      if (wr_acc[c]) mem_q[c][wptr_q[c]] <= in[c*psum_bw +: psum_bw];
    end
  end

  assign out        = out_q;
  assign out_strobe = strobe_q;
  assign overflow   = ovf_q;
  assign o_valid    = valid_c;
  assign o_full     = full_c;
  assign o_ready    = ~full_c;

endmodule

// File: tb/tb_ofifo_col.sv
// Testbench for ofifo_col: directed scenarios plus a randomized run, all
// checked against a queue-per-column reference model.
module tb_ofifo_col;

  localparam int COLS  = 8;
  localparam int PB    = 16;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] din = '0;
  logic [7:0]   wr = '0;
  logic         rd = 1'b0;
  logic [127:0] out;
  logic         out_strobe, o_valid, o_full, o_ready, overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0]  mq [COLS][$];
  logic [127:0] exp_out = '0;
  logic         exp_stb = 1'b0;
  logic         exp_ovf = 1'b0;

  ofifo_col #(.col(COLS), .psum_bw(PB), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd),
    .out(out), .out_strobe(out_strobe), .o_valid(o_valid),
    .o_full(o_full), .o_ready(o_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic m_valid();
    for (int c = 0; c < COLS; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int c = 0; c < COLS; c++) if (mq[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int c = 0; c < COLS; c++) mq[c].delete();
    exp_out = '0; exp_stb = 1'b0; exp_ovf = 1'b0;
  endtask

  // One clock of the reference: pop a whole row if every column has data,
  // then push each strobed column unless it is still full.
  task automatic m_step(input logic [7:0] w, input logic [127:0] d, input logic r);
    logic p;
    p = r && m_valid();
    if (p) for (int c = 0; c < COLS; c++) exp_out[c*16 +: 16] = mq[c].pop_front();
    exp_stb = p;
    for (int c = 0; c < COLS; c++)
      if (w[c]) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(d[c*16 +: 16]);
        else exp_ovf = 1'b1;
      end
  endtask

  // Drive one cycle; leaves the bench at posedge+1 with inputs idle.
  task automatic cyc(input logic [7:0] w, input logic [127:0] d, input logic r);
    wr = w; din = d; rd = r;
    m_step(w, d, r);
    @(posedge clk); #1;
    wr = '0; rd = 1'b0;
  endtask

  function automatic logic [127:0] rnd_row();
    logic [127:0] v;
    for (int c = 0; c < COLS; c++) v[c*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0; #2; reset = 1'b1;
    m_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    m_clear();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    checks++; if (out !== 128'h0) begin errors++; $display("FAIL reset_out got %h exp 0", out); end
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", out_strobe); end
  endtask

  task automatic test_skew();
    logic [127:0] d1, d2;
    for (int c = 0; c < COLS; c++) begin
      d1[c*16 +: 16] = 16'h0100 + 16'(c);
      d2[c*16 +: 16] = 16'h0200 + 16'(c);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(8'((16'h1 << (i + 1)) - 16'h1), d1, 1'b0);
      checks++;
      if (o_valid !== (i == 7)) begin errors++; $display("FAIL skew_valid_%0d got %b exp %b", i, o_valid, (i == 7)); end
    end
    for (int i = 1; i < 8; i++) cyc(8'(8'hFF << i), d2, 1'b0);
    cyc(8'h00, '0, 1'b1);
    checks++; if (out !== d1) begin errors++; $display("FAIL skew_row1 got %h exp %h", out, d1); end
    checks++; if (out_strobe !== 1'b1) begin errors++; $display("FAIL skew_strobe got %b exp 1", out_strobe); end
    cyc(8'h00, '0, 1'b0);
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL skew_strobe_idle got %b exp 0", out_strobe); end
    for (int i = 0; i < 7; i++) begin
      cyc(8'h00, '0, 1'b1);
      checks++; if (out !== exp_out || out_strobe !== 1'b1) begin errors++; $display("FAIL skew_drain_%0d got %h/%b exp %h/1", i, out, out_strobe, exp_out); end
    end
    checks++; if (out[127:112] !== 16'h0207) begin errors++; $display("FAIL skew_last_col7 got %h exp 0207", out[127:112]); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_empty got %b exp 0", o_valid); end
  endtask

  task automatic test_blocked_pop();
    logic [127:0] a, b, row;
    logic [127:0] prev;
    do_reset();
    a = rnd_row(); b = rnd_row();
    cyc(8'hDF, a, 1'b0);
    prev = exp_out;
    cyc(8'h00, '0, 1'b1);
    checks++; if (out !== prev) begin errors++; $display("FAIL blocked_out got %h exp %h", out, prev); end
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL blocked_strobe got %b exp 0", out_strobe); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL blocked_valid got %b exp 0", o_valid); end
    cyc(8'h20, b, 1'b0);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL blocked_valid2 got %b exp 1", o_valid); end
    row = a; row[5*16 +: 16] = b[5*16 +: 16];
    cyc(8'h00, '0, 1'b1);
    checks++; if (out !== row) begin errors++; $display("FAIL blocked_row got %h exp %h", out, row); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL blocked_after got %b exp 0", o_valid); end
  endtask

  task automatic test_fill_overflow();
    logic [127:0] first;
    do_reset();
    first = rnd_row();
    cyc(8'hFF, first, 1'b0);
    for (int i = 1; i < DEPTH; i++) cyc(8'hFF, rnd_row(), 1'b0);
    checks++; if (o_full !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL fill_flags got %b/%b exp 1/0", o_full, o_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_noovf got %b exp 0", overflow); end
    cyc(8'hFF, rnd_row(), 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b exp 1", overflow); end
    cyc(8'h00, '0, 1'b1);
    checks++; if (out !== first) begin errors++; $display("FAIL fill_first got %h exp %h", out, first); end
    for (int i = 1; i < DEPTH; i++) begin
      cyc(8'h00, '0, 1'b1);
      checks++; if (out !== exp_out) begin errors++; $display("FAIL fill_drain_%0d got %h exp %h", i, out, exp_out); end
    end
    checks++; if (o_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL fill_end got %b/%b exp 0/1", o_valid, overflow); end
  endtask

  task automatic test_full_wr_pop();
    logic [127:0] first, beef;
    do_reset();
    beef = {8{16'hBEEF}};
    first = rnd_row();
    cyc(8'hFF, first, 1'b0);
    for (int i = 1; i < DEPTH; i++) cyc(8'hFF, rnd_row(), 1'b0);
    cyc(8'hFF, beef, 1'b1);
    checks++; if (out !== first || out_strobe !== 1'b1) begin errors++; $display("FAIL fwp_pop got %h/%b exp %h/1", out, out_strobe, first); end
    checks++; if (o_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fwp_flags got %b/%b exp 1/0", o_full, overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(8'h00, '0, 1'b1);
      checks++; if (out !== exp_out) begin errors++; $display("FAIL fwp_drain_%0d got %h exp %h", i, out, exp_out); end
    end
    checks++; if (out !== beef) begin errors++; $display("FAIL fwp_last got %h exp %h", out, beef); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fwp_empty got %b exp 0", o_valid); end
  endtask

  task automatic test_async_reset();
    logic [127:0] nr;
    do_reset();
    for (int i = 0; i < 10; i++) cyc(8'hFF, rnd_row(), 1'b0);
    cyc(8'h00, '0, 1'b1);
    #2; reset = 1'b0; #1;
    checks++; if (o_valid !== 1'b0 || o_full !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL areset_flags got %b%b%b exp 001", o_valid, o_full, o_ready); end
    checks++; if (out !== 128'h0 || out_strobe !== 1'b0) begin errors++; $display("FAIL areset_out got %h/%b exp 0/0", out, out_strobe); end
    #1; reset = 1'b1;
    m_clear();
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL areset_after got %b exp 0", o_valid); end
    nr = rnd_row();
    cyc(8'hFF, nr, 1'b0);
    cyc(8'h00, '0, 1'b1);
    checks++; if (out !== nr) begin errors++; $display("FAIL areset_new got %h exp %h", out, nr); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL areset_drained got %b exp 0", o_valid); end
  endtask

  task automatic test_random();
    logic [7:0] w;
    logic       r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      r = ($urandom_range(0, 9) < 4);
      cyc(w, rnd_row(), r);
      checks++;
      if (out !== exp_out || out_strobe !== exp_stb || overflow !== exp_ovf ||
          o_valid !== m_valid() || o_full !== m_full() || o_ready !== !m_full()) begin
        errors++;
        $display("FAIL rand_%0d got %h s%b o%b v%b f%b r%b exp %h s%b o%b v%b f%b", i, out, out_strobe,
                 overflow, o_valid, o_full, o_ready, exp_out, exp_stb, exp_ovf, m_valid(), m_full());
      end
    end
  endtask

  initial begin
    test_reset();
    test_skew();
    test_blocked_pop();
    test_fill_overflow();
    test_full_wr_pop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
